regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the width of write data.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1 each  writeback request present (0 = ALU, 1 = load).
REQ-005 SHALL have ports req0_reg, req1_reg  input  5 each  destination register number.
REQ-006 SHALL have ports req0_data, req1_data  input  DATA_WIDTH each  writeback value.
REQ-007 SHALL have ports req0_ready, req1_ready  output  1 each  request accepted this cycle.
REQ-008 SHALL have port stall  input  1  when high, no request is accepted.
REQ-009 SHALL have port RegWrite  output  1  write enable to the register file.
REQ-010 SHALL have port WriteRegister  output  5  register file write address.
REQ-011 SHALL have port WriteData  output  DATA_WIDTH  register file write data.
REQ-012 SHALL have port drop_count  output  8  number of accepted writes to register 31.

Function
REQ-013 SHALL transfer a request on a rising edge when reqN_valid and reqN_ready are both high.
REQ-014 SHALL derive reqN_ready combinationally from req0_valid, req1_valid, stall and the priority pointer; never both high in the same cycle.
REQ-015 SHALL deassert both readies while stall is high; stall SHALL not alter the priority pointer.
REQ-016 SHALL grant the sole valid requester when only one is valid, regardless of priority pointer.
REQ-017 SHALL, when both are valid, grant the requester indicated by the 1-bit priority pointer (0 -> req0, 1 -> req1).
REQ-018 SHALL, after any transfer, set the priority pointer to the requester not granted (round-robin); pointer unchanged on cycles without a transfer.
REQ-019 SHALL register a transfer into the output stage with 1-cycle latency: the cycle after the transfer edge, WriteRegister = reqN_reg, WriteData = reqN_data, RegWrite = 1.
REQ-020 SHALL, for a transfer whose reqN_reg = 31, still accept it (ready high), hold RegWrite = 0 for that output cycle, and increment drop_count.
REQ-021 SHALL saturate drop_count at 255 (no wrap).
REQ-022 SHALL drive RegWrite = 0 on any cycle following an edge with no transfer; WriteRegister and WriteData SHALL hold their last values.
REQ-023 SHALL accept back-to-back transfers every cycle, sustaining one register file write per cycle.
REQ-024 SHALL, when both requesters target the same register on consecutive grants, present the writes in grant order so the later grant's data is the final register contents.
REQ-025 SHALL not require requesters to hold valid after ready; a deasserted valid with ready low SHALL cause no transfer and no state change.

Reset
REQ-026 SHALL, while reset is high, asynchronously force RegWrite = 0, WriteRegister = 0, WriteData = 0, drop_count = 0, priority pointer = 0, and both readies = 0.
REQ-027 SHALL discard any request presented during the reset-deassertion cycle's preceding edge; first transfer is possible on the first rising edge with reset low.
REQ-028 SHALL, on reset asserted mid-stream, cancel any pending output-stage write (RegWrite low immediately, no register file write on the next edge).

Verification
REQ-029 SHALL be verified: only req0 valid, reg 5, data 0x1234 -> req0_ready = 1; next cycle RegWrite = 1, WriteRegister = 5, WriteData = 0x1234.
REQ-030 SHALL be verified: both valid continuously for 4 cycles after reset -> grants alternate req0, req1, req0, req1; output writes appear one cycle after each grant.
REQ-031 SHALL be verified: req1 valid with reg 31 -> req1_ready = 1, next cycle RegWrite = 0, drop_count = 1; 300 such writes -> drop_count = 255.
REQ-032 SHALL be verified: both valid, stall high for 3 cycles then low -> no readies during stall, pointer unchanged, first grant after stall goes to pointer-selected requester.
REQ-033 SHALL be verified: reset asserted in the cycle RegWrite = 1 -> RegWrite, WriteRegister, WriteData, drop_count all 0 before the next rising edge.
REQ-034 SHALL be verified: req0 reg 7 data 0xA then req1 reg 7 data 0xB granted consecutively -> two writes in that order, register 7 reads back 0xB.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin writeback arbiter that feeds one register-file write port.
// Writes to register 31 are accepted and then dropped, and each one is tallied in a saturating counter.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [4:0]            req0_reg,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [4:0]            req1_reg,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  stall,
    output logic                  RegWrite,
    output logic [4:0]            WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic [7:0]            drop_count
);

    localparam logic [4:0] DROP_REG = 5'd31;

    logic                  ptr_q, ptr_d;
    logic                  wen_q, wen_d;
    logic [4:0]            wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            drop_q, drop_d;
    logic                  grant0, grant1, xfer;
    logic [4:0]            sel_reg;
    logic [DATA_WIDTH-1:0] sel_data;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The pointer decides only when both requesters are valid. Reset and stall block every grant.
    always_comb begin
        grant0   = !reset && !stall && req0_valid && (!req1_valid || !ptr_q);
        grant1   = !reset && !stall && req1_valid && (!req0_valid ||  ptr_q);
        xfer     = grant0 || grant1;
        sel_reg  = grant1 ? req1_reg  : req0_reg;
        sel_data = grant1 ? req1_data : req0_data;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        ptr_d   = ptr_q;
        wen_d   = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        drop_d  = drop_q;
        if (xfer) begin
            ptr_d   = grant0;
            wreg_d  = sel_reg;
            wdata_d = sel_data;
            if (sel_reg == DROP_REG) begin
                drop_d = sat_inc(drop_q);
            end else begin
                wen_d = 1'b1;
            end
        end
    end

    // Output stage: register the granted write, one cycle after the transfer edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= 1'b0;
            wen_q   <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            drop_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            drop_q  <= drop_d;
        end
    end

    assign RegWrite      = wen_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. It runs a behavioural model that checks the outputs on every falling edge.
// Hand-computed expectations pin the model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, stall;
    logic [4:0]  req0_reg, req1_reg;
    logic [63:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [7:0]  drop_count;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_wb_arbiter #(.DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .stall(stall), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the arbitration rules, a pending-write record and a drop tally
    int          m_ptr;
    bit          m_wen;
    logic [4:0]  m_reg;
    logic [63:0] m_data;
    int          m_drop;

    function automatic int winner();
        if (reset || stall) return -1;
        if (req0_valid && req1_valid) return m_ptr;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        int w;
        if (reset) begin
            m_ptr <= 0; m_wen <= 1'b0; m_reg <= '0; m_data <= '0; m_drop <= 0;
        end else begin
            w = winner();
            if (w < 0) begin
                m_wen <= 1'b0;
            end else begin
                m_reg  <= (w == 1) ? req1_reg  : req0_reg;
                m_data <= (w == 1) ? req1_data : req0_data;
                m_wen  <= (((w == 1) ? req1_reg : req0_reg) != 5'd31);
                if (((w == 1) ? req1_reg : req0_reg) == 5'd31)
                    m_drop <= (m_drop >= 255) ? 255 : m_drop + 1;
                m_ptr <= 1 - w;
            end
        end
    end

    always @(negedge clk) begin : compare
        int w;
        w = winner();
        chk("ready0", {63'd0, req0_ready}, {63'd0, w == 0});
        chk("ready1", {63'd0, req1_ready}, {63'd0, w == 1});
        chk("RegWrite", {63'd0, RegWrite}, {63'd0, m_wen});
        chk("WriteRegister", {59'd0, WriteRegister}, {59'd0, m_reg});
        chk("WriteData", WriteData, m_data);
        chk("drop_count", {56'd0, drop_count}, 64'(m_drop));
    end

    // Register-file image built from the write port, plus a log of the writes to register 7
    logic [63:0] tb_rf [32];
    logic [63:0] r7_log [$];
    always @(negedge clk) begin
        if (RegWrite) begin
            tb_rf[WriteRegister] = WriteData;
            if (WriteRegister == 5'd7) r7_log.push_back(WriteData);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] r0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [63:0] d1,
                         input logic st);
        req0_valid = v0; req0_reg = r0; req0_data = d0;
        req1_valid = v1; req1_reg = r1; req1_data = d1;
        stall = st;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_drop", {56'd0, drop_count}, 64'd0);
        chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        reset = 1'b0;

        // Single request from req0
        drive(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b0);
        #3 chk("r029_ready0", {63'd0, req0_ready}, 64'd1);
        chk("r029_ready1", {63'd0, req1_ready}, 64'd0);
        tick(); idle();
        #3 chk("r029_we", {63'd0, RegWrite}, 64'd1);
        chk("r029_addr", {59'd0, WriteRegister}, 64'd5);
        chk("r029_data", WriteData, 64'h1234);
        tick();

        // Both requesters valid back to back: grants alternate, starting with req0
        pulse_reset();
        drive(1'b1, 5'd1, 64'h100, 1'b1, 5'd2, 64'h200, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #3 chk("r030_ready0", {63'd0, req0_ready}, {63'd0, (i % 2) == 0});
            chk("r030_ready1", {63'd0, req1_ready}, {63'd0, (i % 2) == 1});
            if (i > 0) begin
                chk("r030_we", {63'd0, RegWrite}, 64'd1);
                chk("r030_addr", {59'd0, WriteRegister}, (i % 2) == 0 ? 64'd2 : 64'd1);
            end
            tick();
        end
        idle();
        #3 chk("r030_last_addr", {59'd0, WriteRegister}, 64'd2);
        chk("r030_last_data", WriteData, 64'h200);
        tick();

        // Writes to register 31 are dropped, and the counter saturates
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hDEAD, 1'b0);
        #3 chk("r031_ready1", {63'd0, req1_ready}, 64'd1);
        tick(); idle();
        #3 chk("r031_we", {63'd0, RegWrite}, 64'd0);
        chk("r031_drop1", {56'd0, drop_count}, 64'd1);
        tick();
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hBEEF, 1'b0);
        repeat (299) tick();
        idle();
        #3 chk("r031_drop_sat", {56'd0, drop_count}, 64'd255);
        tick();

        // A stall holds the pointer, and the first grant after it follows the pointer (req1)
        pulse_reset();
        drive(1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        drive(1'b1, 5'd4, 64'h44, 1'b1, 5'd6, 64'h66, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #3 chk("r032_stall_r0", {63'd0, req0_ready}, 64'd0);
            chk("r032_stall_r1", {63'd0, req1_ready}, 64'd0);
            tick();
        end
        stall = 1'b0;
        #3 chk("r032_after_r1", {63'd0, req1_ready}, 64'd1);
        chk("r032_after_r0", {63'd0, req0_ready}, 64'd0);
        tick(); idle();
        // A valid that drops while ready is low causes no transfer
        tick();
        #3 chk("r025_no_we", {63'd0, RegWrite}, 64'd0);
        chk("r025_hold_addr", {59'd0, WriteRegister}, 64'd6);
        tick();

        // Reset asserted mid-stream clears the pending write at once
        drive(1'b1, 5'd31, 64'h1, 1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        drive(1'b1, 5'd9, 64'h55, 1'b0, 5'd0, 64'd0, 1'b0);
        tick(); idle();
        chk("r033_pre_we", {63'd0, RegWrite}, 64'd1);
        chk("r033_pre_drop", {56'd0, drop_count}, 64'd1);
        #1 reset = 1'b1;
        #1 chk("r033_we", {63'd0, RegWrite}, 64'd0);
        chk("r033_addr", {59'd0, WriteRegister}, 64'd0);
        chk("r033_data", WriteData, 64'd0);
        chk("r033_drop", {56'd0, drop_count}, 64'd0);
        // A request presented while reset is held must not be accepted
        drive(1'b1, 5'd4, 64'h4, 1'b0, 5'd0, 64'd0, 1'b0);
        #1 chk("r027_ready_in_reset", {63'd0, req0_ready}, 64'd0);
        tick();
        chk("r027_no_we", {63'd0, RegWrite}, 64'd0);
        reset = 1'b0;
        idle();
        tick();

        // Consecutive grants to the same register land in grant order
        pulse_reset();
        drive(1'b1, 5'd7, 64'hA, 1'b1, 5'd7, 64'hB, 1'b0);
        #3 chk("r034_first_r0", {63'd0, req0_ready}, 64'd1);
        tick();
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hB, 1'b0);
        #3 chk("r034_second_r1", {63'd0, req1_ready}, 64'd1);
        chk("r034_first_data", WriteData, 64'hA);
        tick(); idle();
        #3 chk("r034_second_data", WriteData, 64'hB);
        chk("r034_second_addr", {59'd0, WriteRegister}, 64'd7);
        tick();
        #3 chk("r034_rf7", tb_rf[7], 64'hB);
        chk("r034_log_len", 64'(r7_log.size()), 64'd2);
        if (r7_log.size() == 2) begin
            chk("r034_log0", r7_log[0], 64'hA);
            chk("r034_log1", r7_log[1], 64'hB);
        end
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
